// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU/MDU: operation codes, FSM states
// and the counter-width helper.
package alu_pkg;

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_NOR   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULTU = 4'b1000;
   localparam logic [3:0] OP_DIVU  = 4'b1001;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

   // Bits needed to count 0..n-1.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Request/response bundle between the control unit (master) and the ALU/MDU (slave).
interface alu_mdu_if #(parameter int WIDTH = 32);

   // Handshake: start is sampled only while busy=0 and then captures ALUctr/busA/busB;
   // busy stays high from the next cycle through the done cycle; done pulses for one
   // cycle and busC/zero/overflow/hi/lo are valid from it and hold until the next done.
   logic             start;
   logic [3:0]       ALUctr;
   logic [WIDTH-1:0] busA;
   logic [WIDTH-1:0] busB;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] busC;
   logic             zero;
   logic             overflow;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output start, ALUctr, busA, busB,
      input  busy, done, busC, zero, overflow, hi, lo
   );

   modport slave (
      input  start, ALUctr, busA, busB,
      output busy, done, busC, zero, overflow, hi, lo
   );

endinterface

// File: rtl/mdu_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring) engine sharing one
// 2*WIDTH accumulator; the parent FSM sequences it with load/step and watches last.
module mdu_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             last,
   output logic [WIDTH-1:0] next_hi,
   output logic [WIDTH-1:0] next_lo
);

   localparam int CW = clog2(WIDTH);

   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;
   logic [WIDTH-1:0] b_q;
   logic             mode_q;
   logic [CW-1:0]    cnt;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_top;
   logic [WIDTH+1:0] div_diff;
   logic             div_geq;

   assign last = (cnt == CW'(WIDTH - 1));

   // next_hi/next_lo are the accumulator after the current step, so the parent can
   // capture the final product/quotient on the same edge as the last iteration.
   always_comb begin
      mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
      div_top  = {acc_hi, acc_lo[WIDTH-1]};
      div_diff = {1'b0, div_top} - {2'b00, b_q};
      // A non-negative trial remainder is always below b, so both top bits are clear.
      div_geq  = (div_diff[WIDTH+1:WIDTH] == 2'b00);
      if (mode_q) begin
         next_hi = div_geq ? div_diff[WIDTH-1:0] : div_top[WIDTH-1:0];
         next_lo = {acc_lo[WIDTH-2:0], div_geq};
      end else begin
         next_hi = mul_sum[WIDTH:1];
         next_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_hi <= '0;
         acc_lo <= '0;
         b_q    <= '0;
         mode_q <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         acc_hi <= '0;
         acc_lo <= a;
         b_q    <= b;
         mode_q <= div_mode;
         cnt    <= '0;
      end else if (step) begin
         acc_hi <= next_hi;
         acc_lo <= next_lo;
         cnt    <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// Multi-cycle ALU: single-cycle logic/arith/compare ops plus iterative MULTU/DIVU
// into HI/LO, behind a start/busy/done handshake.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic   clk,
   input  logic   rst_n,
   alu_mdu_if.slave bus,
   output state_t fsm_state
);

   state_t state;
   state_t next_state;
   logic   load;
   logic   step;
   logic   busy;
   logic   done;
   logic   last;

   logic [WIDTH-1:0] next_hi;
   logic [WIDTH-1:0] next_lo;
   logic [WIDTH-1:0] sum;
   logic [WIDTH-1:0] diff;
   logic [WIDTH-1:0] sc_res;
   logic             sc_ovf;

   logic [WIDTH-1:0] busc_q;
   logic             zero_q;
   logic             ovf_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (bus.start) begin
               if (bus.ALUctr == OP_MULTU)     next_state = MUL;
               else if (bus.ALUctr == OP_DIVU) next_state = DIV;
               else                            next_state = DONE;
            end
         end
         MUL, DIV: if (last) next_state = DONE;
         DONE:     next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   always_comb begin
      load = (state == IDLE) && bus.start;
      step = (state == MUL) || (state == DIV);
      busy = (state != IDLE);
      done = (state == DONE);
   end

   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .step     (step),
      .div_mode (bus.ALUctr == OP_DIVU),
      .a        (bus.busA),
      .b        (bus.busB),
      .last     (last),
      .next_hi  (next_hi),
      .next_lo  (next_lo)
   );

   // Overflow: same-sign operands (ADD) or opposite-sign operands (SUB) whose result
   // sign differs from A.
   always_comb begin
      sum    = bus.busA + bus.busB;
      diff   = bus.busA - bus.busB;
      sc_res = '0;
      sc_ovf = 1'b0;
      case (bus.ALUctr)
         OP_AND: sc_res = bus.busA & bus.busB;
         OP_OR:  sc_res = bus.busA | bus.busB;
         OP_NOR: sc_res = ~(bus.busA | bus.busB);
         OP_ADD: begin
            sc_res = sum;
            sc_ovf = (bus.busA[WIDTH-1] == bus.busB[WIDTH-1]) &&
                     (sum[WIDTH-1] != bus.busA[WIDTH-1]);
         end
         OP_SUB: begin
            sc_res = diff;
            sc_ovf = (bus.busA[WIDTH-1] != bus.busB[WIDTH-1]) &&
                     (diff[WIDTH-1] != bus.busA[WIDTH-1]);
         end
         OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(bus.busA) < $signed(bus.busB))};
         default: begin
            sc_res = '0;
            sc_ovf = 1'b0;
         end
      endcase
   end

   // Result registers load on the edge that enters DONE, so they are valid in the
   // done cycle and hold otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busc_q <= '0;
         zero_q <= 1'b0;
         ovf_q  <= 1'b0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else if (load && next_state == DONE) begin
         busc_q <= sc_res;
         zero_q <= (sc_res == '0);
         ovf_q  <= sc_ovf;
      end else if (step && last) begin
         busc_q <= next_lo;
         zero_q <= (next_lo == '0);
         ovf_q  <= 1'b0;
         hi_q   <= next_hi;
         lo_q   <= next_lo;
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.busC     = busc_q;
   assign bus.zero     = zero_q;
   assign bus.overflow = ovf_q;
   assign bus.hi       = hi_q;
   assign bus.lo       = lo_q;
   assign fsm_state    = state;

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboarded random + directed bench for alu_mdu at WIDTH=32 and WIDTH=8.
module tb_alu_mdu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_mdu_if #(.WIDTH(32)) bus32();
   alu_mdu_if #(.WIDTH(8))  bus8();
   state_t st32;
   state_t st8;

   alu_mdu #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave), .fsm_state(st32));
   alu_mdu #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave),  .fsm_state(st8));

   typedef struct {
      logic [63:0] c;
      logic [63:0] hi;
      logic [63:0] lo;
      logic        z;
      logic        v;
      int          t0;
      int          lat;
   } exp_t;

   exp_t        exp32_q[$];
   exp_t        exp8_q[$];
   logic [63:0] m32_hi = '0, m32_lo = '0, m8_hi = '0, m8_lo = '0;
   int          n_checks = 0;
   int          n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
      end
   endtask

   // Reference: operands as integers, results from plain arithmetic.
   function automatic exp_t model(input int w, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input logic [63:0] hi_in,
                                  input logic [63:0] lo_in);
      exp_t        e;
      logic [63:0] mask;
      logic [63:0] p;
      longint      sa, sb, r, smax, smin;
      mask = (64'd1 << w) - 64'd1;
      sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      smax = (longint'(1) << (w - 1)) - 1;
      smin = -(longint'(1) << (w - 1));
      e.c = '0; e.v = 1'b0; e.hi = hi_in; e.lo = lo_in; e.lat = 1; e.t0 = 0;
      case (op)
         OP_AND: e.c = a & b;
         OP_OR:  e.c = a | b;
         OP_NOR: e.c = ~(a | b) & mask;
         OP_ADD: begin r = sa + sb; e.c = 64'(r) & mask; e.v = (r > smax) || (r < smin); end
         OP_SUB: begin r = sa - sb; e.c = 64'(r) & mask; e.v = (r > smax) || (r < smin); end
         OP_SLT: e.c = (sa < sb) ? 64'd1 : 64'd0;
         OP_MULTU: begin
            p = a * b;
            e.hi = p >> w; e.lo = p & mask; e.c = e.lo; e.lat = w + 1;
         end
         OP_DIVU: begin
            if (b == 0) begin e.lo = mask; e.hi = a; end
            else begin e.lo = a / b; e.hi = a % b; end
            e.c = e.lo; e.lat = w + 1;
         end
         default: e.c = '0;
      endcase
      e.z = (e.c == 0);
      return e;
   endfunction

   task automatic compare_exp(input string tag, input exp_t e, input logic [63:0] c,
                              input logic z, input logic v, input logic [63:0] hi,
                              input logic [63:0] lo, input int busy_run);
      check({tag, " busC"}, c, e.c);
      check({tag, " zero"}, 64'(z), 64'(e.z));
      check({tag, " overflow"}, 64'(v), 64'(e.v));
      check({tag, " hi"}, hi, e.hi);
      check({tag, " lo"}, lo, e.lo);
      check({tag, " latency"}, 64'(cyc - e.t0), 64'(e.lat));
      check({tag, " busy cycles"}, 64'(busy_run + 1), 64'(e.lat));
   endtask

   int busy_run32 = 0;
   int busy_run8 = 0;

   always @(negedge clk) begin
      exp_t e;
      if (bus32.done) begin
         if (exp32_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL w32 unexpected done at cycle %0d, expected no done", cyc);
         end else begin
            e = exp32_q.pop_front();
            compare_exp("w32", e, 64'(bus32.busC), bus32.zero, bus32.overflow,
                        64'(bus32.hi), 64'(bus32.lo), busy_run32);
         end
      end
      busy_run32 = bus32.busy ? busy_run32 + 1 : 0;
   end

   always @(negedge clk) begin
      exp_t e;
      if (bus8.done) begin
         if (exp8_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL w8 unexpected done at cycle %0d, expected no done", cyc);
         end else begin
            e = exp8_q.pop_front();
            compare_exp("w8", e, 64'(bus8.busC), bus8.zero, bus8.overflow,
                        64'(bus8.hi), 64'(bus8.lo), busy_run8);
         end
      end
      busy_run8 = bus8.busy ? busy_run8 + 1 : 0;
   end

   task automatic issue(input int w, input logic [3:0] op, input logic [63:0] a,
                        input logic [63:0] b, output int t0);
      exp_t e;
      @(negedge clk);
      t0 = cyc;
      if (w == 32) begin
         bus32.start = 1'b1; bus32.ALUctr = op; bus32.busA = a[31:0]; bus32.busB = b[31:0];
         e = model(32, op, {32'd0, a[31:0]}, {32'd0, b[31:0]}, m32_hi, m32_lo);
         e.t0 = t0; m32_hi = e.hi; m32_lo = e.lo;
         exp32_q.push_back(e);
      end else begin
         bus8.start = 1'b1; bus8.ALUctr = op; bus8.busA = a[7:0]; bus8.busB = b[7:0];
         e = model(8, op, {56'd0, a[7:0]}, {56'd0, b[7:0]}, m8_hi, m8_lo);
         e.t0 = t0; m8_hi = e.hi; m8_lo = e.lo;
         exp8_q.push_back(e);
      end
      @(negedge clk);
      // Scramble inputs after accept: the DUT must work from its own copies.
      bus32.start = 1'b0; bus32.busA = $urandom; bus32.busB = $urandom;
      bus8.start = 1'b0;  bus8.busA = 8'($urandom); bus8.busB = 8'($urandom);
   endtask

   task automatic wait_idle(input int w);
      for (int i = 0; i < 100; i++) begin
         if ((w == 32) ? !bus32.busy : !bus8.busy) return;
         @(negedge clk);
      end
      n_checks++; n_fail++;
      $display("FAIL w%0d busy timeout: still busy after 100 cycles, expected idle", w);
   endtask

   task automatic run(input int w, input logic [3:0] op, input logic [63:0] a, input logic [63:0] b);
      int t0;
      issue(w, op, a, b, t0);
      wait_idle(w);
   endtask

   function automatic logic [3:0] rand_op();
      logic [3:0] ops[9];
      ops = '{OP_AND, OP_OR, OP_ADD, OP_NOR, OP_SUB, OP_SLT, OP_MULTU, OP_DIVU, 4'd0};
      ops[8] = 4'($urandom_range(0, 15));
      return ops[$urandom_range(0, 8)];
   endfunction

   function automatic logic [63:0] rand_opnd(input int w);
      logic [63:0] mask;
      logic [63:0] sp[4];
      mask = (64'd1 << w) - 64'd1;
      sp = '{64'd0, mask, 64'd1 << (w - 1), mask >> 1};
      if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 3)];
      return {$urandom, $urandom} & mask;
   endfunction

   task automatic check_reset_outputs(input string tag);
      check({tag, " w32 busy"}, 64'(bus32.busy), 64'd0);
      check({tag, " w32 done"}, 64'(bus32.done), 64'd0);
      check({tag, " w32 busC"}, 64'(bus32.busC), 64'd0);
      check({tag, " w32 zero"}, 64'(bus32.zero), 64'd0);
      check({tag, " w32 overflow"}, 64'(bus32.overflow), 64'd0);
      check({tag, " w32 hi"}, 64'(bus32.hi), 64'd0);
      check({tag, " w32 lo"}, 64'(bus32.lo), 64'd0);
      check({tag, " w32 state"}, 64'(st32), 64'(IDLE));
      check({tag, " w8 busy"}, 64'(bus8.busy), 64'd0);
      check({tag, " w8 hi"}, 64'(bus8.hi), 64'd0);
   endtask

   initial begin
      int t0;
      // Reset with start held high: reset must win.
      rst_n = 1'b0;
      bus32.start = 1'b1; bus32.ALUctr = OP_ADD; bus32.busA = 32'd2; bus32.busB = 32'd3;
      bus8.start = 1'b1;  bus8.ALUctr = OP_ADD;  bus8.busA = 8'd2;   bus8.busB = 8'd3;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      bus32.start = 1'b0; bus8.start = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);

      run(32, OP_ADD, 64'h7FFF_FFFF, 64'h1);
      run(32, OP_SUB, 64'd5, 64'd5);
      run(32, OP_SLT, 64'hFFFF_FFFF, 64'h1);
      run(32, OP_SLT, 64'h1, 64'hFFFF_FFFF);
      run(32, 4'b0101, 64'h1234, 64'h5678);
      run(32, OP_MULTU, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      run(32, OP_DIVU, 64'd100, 64'd7);
      run(32, OP_DIVU, 64'hA, 64'd0);
      run(32, OP_ADD, 64'd1, 64'd1);

      // start pulses in cycles 5 and 33 of a MULTU must be ignored.
      issue(32, OP_MULTU, 64'h1234_5678, 64'h9ABC_DEF0, t0);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         bus32.ALUctr = OP_ADD;
         bus32.start  = (cyc == t0 + 5) || (cyc == t0 + 33);
      end
      bus32.start = 1'b0;
      wait_idle(32);

      // Reset in cycle 10 of a DIVU aborts it without a done.
      issue(32, OP_DIVU, 64'hDEAD_BEEF, 64'h123, t0);
      while (cyc < t0 + 10) @(negedge clk);
      rst_n = 1'b0;
      exp32_q.delete(); exp8_q.delete();
      m32_hi = '0; m32_lo = '0; m8_hi = '0; m8_lo = '0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset_outputs("abort");
      run(32, OP_ADD, 64'd2, 64'd3);

      for (int i = 0; i < 30; i++) run(32, rand_op(), rand_opnd(32), rand_opnd(32));

      run(8, OP_MULTU, 64'hFF, 64'hFF);
      run(8, OP_DIVU, 64'hC8, 64'd0);
      for (int i = 0; i < 20; i++) run(8, rand_op(), rand_opnd(8), rand_opnd(8));

      repeat (3) @(negedge clk);
      check("w32 scoreboard drained", 64'(exp32_q.size()), 64'd0);
      check("w8 scoreboard drained", 64'(exp8_q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_mdu.md
# alu_mdu

Parametrised multi-cycle successor to the single-cycle datapath ALU. It executes logic, arithmetic and compare operations in one registered cycle, and unsigned multiply/divide iteratively over WIDTH cycles into HI/LO registers. It uses a start/busy/done handshake so the control unit can stall the pipeline. Flags (zero, overflow) are valid for every operation, not only subtract.

## Interface
- WIDTH, 32, operand/result width; legal range 4..64.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- ALUctr  in  4  operation code, captured with start.
- busA  in  WIDTH  operand A, captured with start.
- busB  in  WIDTH  operand B, captured with start.
- busy  out  1  high from the cycle after start is accepted through the done cycle.
- done  out  1  one-cycle pulse; busC/zero/overflow/hi/lo are valid from this cycle.
- busC  out  WIDTH  registered result.
- zero  out  1  busC == 0.
- overflow  out  1  signed overflow for ADD/SUB; 0 otherwise.
- hi  out  WIDTH  MULTU upper product / DIVU remainder.
- lo  out  WIDTH  MULTU lower product / DIVU quotient.

## Operation
- Codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 NOR
  - 0110 SUB
  - 0111 SLT (signed; busC = 1 or 0)
  - 1000 MULTU
  - 1001 DIVU
- All other codes: busC=0, zero=1, overflow=0; completes as a single-cycle op.
- ADD/SUB are modulo 2^WIDTH. Overflow is set when the operand signs imply the opposite result sign.
- MULTU: shift-add over WIDTH iterations; {hi,lo} = A*B (2*WIDTH bits); busC = lo.
- DIVU: restoring division over WIDTH iterations; lo = A/B, hi = A%B, busC = lo.
- Divide by zero is not special-cased. It must yield lo = all ones and hi = A after the full WIDTH iterations.
- hi/lo change only on MULTU/DIVU completion. busC/zero/overflow change only on the done cycle of each operation. All outputs hold between operations.
- FSM:
  - IDLE: on start, capture operands and code. Go to DONE for single-cycle codes, MUL for 1000, DIV for 1001.
  - MUL/DIV: one iteration per cycle, iteration counter 0..WIDTH-1. After iteration WIDTH-1, go to DONE.
  - DONE: done=1; return to IDLE.
- busy = (state != IDLE).
- start is ignored while busy, including the DONE cycle, so peak throughput is one op every 2 cycles.

## Timing
- Reset: state IDLE; busy, done, busC, zero, overflow, hi, lo all 0; counter 0.
- Latency, counted from the cycle start is high (cycle 0) to the done cycle:
  - single-cycle ops: done in cycle 1.
  - MULTU/DIVU: done in cycle WIDTH+1; busy high in cycles 1..WIDTH+1.
- rst_n low mid-operation aborts immediately. No done pulse is produced and outputs return to reset values at that edge.
- rst_n low takes priority over start in the same cycle.
- Operand inputs may change freely after the accept edge; internal copies are used.

## Structure
- Package alu_pkg holds:
  - ALUctr code localparams.
  - FSM state enum (IDLE, MUL, DIV, DONE).
  - The counter width function clog2(WIDTH).
- One sub-module, mdu_iter, owns the shared 2*WIDTH accumulator, the shift-add/restoring step and the counter. It has load/step/last signals controlled by the alu_mdu FSM.
- The single-cycle op logic stays in the top level.

## Test plan
- ADD, WIDTH=32: 0x7FFFFFFF + 0x00000001 → done in cycle 1; busC=0x80000000, overflow=1, zero=0. SUB 5-5 → busC=0, zero=1, overflow=0.
- SLT: 0xFFFFFFFF vs 0x00000001 → busC=1. Reversed operands → busC=0, zero=1. Code 0101 → busC=0, zero=1.
- MULTU: 0xFFFFFFFF * 0xFFFFFFFF → hi=0xFFFFFFFE, lo=busC=0x00000001. done exactly in cycle 33; busy high 33 cycles.
- DIVU:
  - 100/7 → lo=14, hi=2.
  - 0x0000000A/0 → lo=0xFFFFFFFF, hi=0x0000000A.
  - A following ADD leaves hi/lo unchanged.
- Handshake/reset:
  - start pulsed in cycles 5 and 33 of a MULTU → both ignored.
  - rst_n low in cycle 10 of a DIVU → no done; all outputs 0 next cycle; a subsequent ADD 2+3 gives busC=5.
- WIDTH=8 instance: MULTU 0xFF*0xFF → hi=0xFE, lo=0x01, done in cycle 9.
